// File: rtl/bin_to_bcd_display.sv
// Iterative double-dabble converter: unsigned binary in, six packed BCD digits out
// for the 24-bit seven-segment decoder. One shift-add-3 iteration per clock.
module bin_to_bcd_display #(
    parameter int BIN_WIDTH = 20,
    parameter int MAX_DEC   = 999999
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] in_bin,
    output logic [23:0]          bcd_out,
    output logic                 bcd_valid,
    output logic                 busy,
    output logic                 overflow
);

    localparam int SR_W  = 24 + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_step;
    logic              accept;
    logic              in_over;
    logic              last_iter;

    // Add 3 to every nibble >= 5; all nibbles judged on the incoming value.
    function automatic logic [23:0] add3_digits(input logic [23:0] bcd);
        logic [23:0] r;
        r = bcd;
        for (int d = 0; d < 6; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5)
                r[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] adj;
        adj = {add3_digits(v[SR_W-1:BIN_WIDTH]), v[BIN_WIDTH-1:0]};
        return adj << 1;
    endfunction

    function automatic logic exceeds_max(input logic [BIN_WIDTH-1:0] v);
        logic [31:0] ext;
        ext = 32'(v);
        return ext > 32'(MAX_DEC);
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_over   = exceeds_max(in_bin);
    assign last_iter = (cnt == LAST_ITER);
    assign sr_step   = dabble_step(sr);

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !in_over) state_nx = CONVERT;
            CONVERT: if (last_iter)          state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == CONVERT);
    end

    // Iteration counter and committed outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            bcd_out   <= 24'h000000;
            bcd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept && in_over) begin
                        bcd_out   <= 24'h999999;
                        overflow  <= 1'b1;
                        bcd_valid <= 1'b1;
                    end
                end
                CONVERT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        bcd_out   <= sr_step[SR_W-1:BIN_WIDTH];
                        overflow  <= 1'b0;
                        bcd_valid <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Working shift register is pure data; the FSM decides when it matters.
    always_ff @(posedge clock) begin
        if (state == IDLE && accept)
            sr <= {24'h000000, in_bin};
        else if (state == CONVERT)
            sr <= sr_step;
    end

    // Input bounded by MAX_DEC means no digit can exceed 9 once conversion ends.
    always @(posedge clock) begin
        if (!reset && state == CONVERT && last_iter) begin
            for (int d = 0; d < 6; d++)
                assert (sr_step[BIN_WIDTH + d*4 +: 4] <= 4'd9);
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed and randomized checks of bin_to_bcd_display against a decimal reference.
module tb_bin_to_bcd_display;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_bin = '0;
    logic [23:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic        overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bin_to_bcd_display #(.BIN_WIDTH(20)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'h999999;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Present v, wait for the accept edge, then count edges until bcd_valid.
    task automatic do_convert(input logic [19:0] v, output int lat,
                              output logic [23:0] res, output logic ov);
        @(negedge clock);
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
        while (!bcd_valid && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        if (!bcd_valid) lat = -1;
        res = bcd_out;
        ov  = overflow;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if ({bcd_out, bcd_valid, overflow, busy, in_ready} !== {24'h000000, 4'b0001})
            $display("FAIL reset_state got bcd=%h v=%b ov=%b busy=%b rdy=%b required bcd=000000 v=0 ov=0 busy=0 rdy=1",
                     bcd_out, bcd_valid, overflow, busy, in_ready);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int lat; logic [23:0] res; logic ov;
        do_convert(20'd0, lat, res, ov);
        total_cnt++;
        if (lat !== 20) $display("FAIL zero_latency got %0d required 20", lat);
        else pass_cnt++;
        total_cnt++;
        if ({res, ov} !== {24'h000000, 1'b0}) $display("FAIL zero_value got %h ov=%b required 000000 ov=0", res, ov);
        else pass_cnt++;
    endtask

    task automatic test_123456();
        int busy_n = 0, nrdy_n = 0, vld_at = -1;
        @(negedge clock);
        in_bin   = 20'h1E240;
        in_valid = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (busy) busy_n++;
            if (!in_ready) nrdy_n++;
            if (bcd_valid && vld_at < 0) vld_at = k;
            if (k == 20) begin
                total_cnt++;
                if (bcd_out !== 24'h123456) $display("FAIL conv_123456 got %h required 123456", bcd_out);
                else pass_cnt++;
            end
            @(posedge clock);
        end
        total_cnt++;
        if (vld_at !== 20) $display("FAIL conv_123456_latency got %0d required 20", vld_at);
        else pass_cnt++;
        total_cnt++;
        if (busy_n !== 20) $display("FAIL busy_window got %0d required 20", busy_n);
        else pass_cnt++;
        total_cnt++;
        if (nrdy_n !== 20) $display("FAIL ready_low_window got %0d required 20", nrdy_n);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat; logic [23:0] res; logic ov;
        do_convert(20'hF423F, lat, res, ov);
        total_cnt++;
        if ({res, ov} !== {24'h999999, 1'b0}) $display("FAIL max_dec got %h ov=%b required 999999 ov=0", res, ov);
        else pass_cnt++;
        // One above the 6-digit limit: committed on the accept edge, no conversion run
        @(negedge clock);
        in_bin   = 20'hF4240;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        total_cnt++;
        if ({bcd_out, overflow, bcd_valid, busy, in_ready} !== {24'h999999, 4'b1101})
            $display("FAIL over_max got bcd=%h ov=%b v=%b busy=%b rdy=%b required 999999 ov=1 v=1 busy=0 rdy=1",
                     bcd_out, overflow, bcd_valid, busy, in_ready);
        else pass_cnt++;
        @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if ({bcd_valid, busy, overflow} !== 3'b001)
            $display("FAIL over_max_after got v=%b busy=%b ov=%b required v=0 busy=0 ov=1", bcd_valid, busy, overflow);
        else pass_cnt++;
        do_convert(20'd305, lat, res, ov);
        total_cnt++;
        if ({res, ov} !== {24'h000305, 1'b0}) $display("FAIL ovf_clear got %h ov=%b required 000305 ov=0", res, ov);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int first_at = -1, second_at = -1, extra = 0;
        logic [23:0] first_val = '0, second_val = '0;
        logic rdy20 = 1'b0;
        @(negedge clock);
        in_bin   = 20'd42;
        in_valid = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 46; k++) begin
            @(negedge clock);
            if (k == 0) in_bin = 20'd7;
            if (k == 20) rdy20 = in_ready;
            if (k == 21) in_valid = 1'b0;
            if (bcd_valid) begin
                if (first_at < 0) begin first_at = k; first_val = bcd_out; end
                else if (second_at < 0) begin second_at = k; second_val = bcd_out; end
                else extra++;
            end
            @(posedge clock);
        end
        total_cnt++;
        if (first_at !== 20 || first_val !== 24'h000042)
            $display("FAIL b2b_first got at=%0d val=%h required at=20 val=000042", first_at, first_val);
        else pass_cnt++;
        total_cnt++;
        if (rdy20 !== 1'b1) $display("FAIL b2b_ready got %b required 1", rdy20);
        else pass_cnt++;
        total_cnt++;
        if (second_at !== 41 || second_val !== 24'h000007 || extra !== 0)
            $display("FAIL b2b_second got at=%0d val=%h extra=%0d required at=41 val=000007 extra=0",
                     second_at, second_val, extra);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        int lat; logic [23:0] res; logic ov;
        @(negedge clock);
        in_bin   = 20'd500000;
        in_valid = 1'b1;
        @(posedge clock);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (k < 10) @(posedge clock);
        end
        total_cnt++;
        if (bcd_out !== 24'h000007 || busy !== 1'b1)
            $display("FAIL abort_hold got bcd=%h busy=%b required 000007 busy=1", bcd_out, busy);
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if ({bcd_out, bcd_valid, overflow, busy, in_ready} !== {24'h000000, 4'b0001})
            $display("FAIL abort_reset got bcd=%h v=%b ov=%b busy=%b rdy=%b required 000000 0 0 0 1",
                     bcd_out, bcd_valid, overflow, busy, in_ready);
        else pass_cnt++;
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bcd_valid || busy) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL abort_no_pulse got %0d required 0", pulses);
        else pass_cnt++;
        do_convert(20'd9, lat, res, ov);
        total_cnt++;
        if (res !== 24'h000009 || lat !== 20) $display("FAIL after_abort got %h lat=%0d required 000009 lat=20", res, lat);
        else pass_cnt++;
    endtask

    task automatic test_reset_with_valid();
        int activity = 0;
        @(negedge clock);
        reset    = 1'b1;
        in_bin   = 20'd5;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (busy || bcd_valid) activity++;
            @(posedge clock);
            @(negedge clock);
        end
        total_cnt++;
        if (activity !== 0 || bcd_out !== 24'h000000)
            $display("FAIL reset_wins got activity=%0d bcd=%h required 0 000000", activity, bcd_out);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        int lat; logic [23:0] res; logic ov;
        int unsigned v;
        logic nib_ok;
        for (int n = 0; n < 2000; n++) begin
            v = $urandom_range(0, 1048575);
            do_convert(20'(v), lat, res, ov);
            total_cnt++;
            if (res !== ref_bcd(v) || ov !== (v > 999999))
                $display("FAIL sweep_value in=%0d got %h ov=%b required %h ov=%b", v, res, ov, ref_bcd(v), v > 999999);
            else pass_cnt++;
            total_cnt++;
            if (lat !== ((v > 999999) ? 0 : 20))
                $display("FAIL sweep_latency in=%0d got %0d required %0d", v, lat, (v > 999999) ? 0 : 20);
            else pass_cnt++;
            nib_ok = 1'b1;
            for (int d = 0; d < 6; d++) if (res[d*4 +: 4] > 4'd9) nib_ok = 1'b0;
            total_cnt++;
            if (nib_ok !== 1'b1) $display("FAIL sweep_digit_range in=%0d got %h required all digits <= 9", v, res);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_123456();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_reset_with_valid();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
